// File: rtl/usb_rx_pkt.sv
// USB receive packet decoder: PID check, payload forwarding through a 2-byte
// delay line so the trailing CRC16 bytes are never forwarded, and CRC16 check.
module usb_rx_pkt #(
  parameter int MAX_BYTES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_active,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_error,
  output logic [3:0] pid,
  output logic       is_data,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       pkt_done,
  output logic       crc_ok,
  output logic       pkt_err,
  output logic [6:0] byte_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PID,
    S_DATA,
    S_HSK,
    S_ERR,
    S_DONE
  } state_t;

  localparam logic [6:0] LP_MAX = 7'(MAX_BYTES);

  state_t      r_state;
  logic [15:0] r_crc;
  logic [7:0]  r_hold0;
  logic [7:0]  r_hold1;
  logic [1:0]  r_nheld;
  logic        r_armed;

  logic        w_pid_ok;
  logic        w_pid_data;

  // USB CRC16, reflected polynomial, one byte shifted in LSB first
  function automatic logic [15:0] f_crc16_byte(input logic [15:0] crc, input logic [7:0] d);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 16'hA001;
      else             c = c >> 1;
    end
    return c;
  endfunction

  assign w_pid_ok   = (rx_data[7:4] == ~rx_data[3:0]);
  assign w_pid_data = (rx_data[3:0] == 4'h3) || (rx_data[3:0] == 4'hB) ||
                      (rx_data[3:0] == 4'h7) || (rx_data[3:0] == 4'hF);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_armed    <= 1'b0;
      r_crc      <= 16'h0000;
      r_hold0    <= 8'h00;
      r_hold1    <= 8'h00;
      r_nheld    <= 2'd0;
      pid        <= 4'h0;
      is_data    <= 1'b0;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      pkt_done   <= 1'b0;
      crc_ok     <= 1'b0;
      pkt_err    <= 1'b0;
      byte_cnt   <= 7'd0;
    end else begin
      data_valid <= 1'b0;
      pkt_done   <= 1'b0;
      // a packet already in flight when reset lifts is skipped until the line idles
      if (!rx_active) r_armed <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (rx_active && r_armed) begin
            r_state  <= S_PID;
            crc_ok   <= 1'b0;
            pkt_err  <= 1'b0;
            byte_cnt <= 7'd0;
            r_crc    <= 16'hFFFF;
            r_nheld  <= 2'd0;
          end
        end

        S_PID: begin
          if (rx_error) begin
            r_state <= S_ERR;
            pkt_err <= 1'b1;
          end else if (!rx_active) begin
            r_state  <= S_DONE;
            pkt_done <= 1'b1;
          end else if (rx_valid) begin
            pid     <= rx_data[3:0];
            is_data <= w_pid_data;
            if (!w_pid_ok) begin
              r_state <= S_ERR;
              pkt_err <= 1'b1;
            end else if (w_pid_data) begin
              r_state <= S_DATA;
            end else begin
              r_state <= S_HSK;
            end
          end
        end

        S_DATA: begin
          if (rx_error) begin
            r_state <= S_ERR;
            pkt_err <= 1'b1;
          end else if (!rx_active) begin
            r_state  <= S_DONE;
            pkt_done <= 1'b1;
            if (r_nheld != 2'd2) begin
              pkt_err <= 1'b1;
              crc_ok  <= 1'b0;
            end else begin
              crc_ok <= ({r_hold1, r_hold0} == ~r_crc);
            end
          end else if (rx_valid) begin
            if (r_nheld != 2'd2) begin
              r_hold0 <= r_hold1;
              r_hold1 <= rx_data;
              r_nheld <= r_nheld + 2'd1;
            end else if (byte_cnt == LP_MAX) begin
              r_state <= S_ERR;
              pkt_err <= 1'b1;
            end else begin
              data_out   <= r_hold0;
              data_valid <= 1'b1;
              byte_cnt   <= byte_cnt + 7'd1;
              r_crc      <= f_crc16_byte(r_crc, r_hold0);
              r_hold0    <= r_hold1;
              r_hold1    <= rx_data;
            end
          end
        end

        S_HSK: begin
          if (rx_error) begin
            r_state <= S_ERR;
            pkt_err <= 1'b1;
          end else if (!rx_active) begin
            r_state  <= S_DONE;
            pkt_done <= 1'b1;
          end else if (rx_valid) begin
            r_state <= S_ERR;
            pkt_err <= 1'b1;
          end
        end

        S_ERR: begin
          pkt_err <= 1'b1;
          crc_ok  <= 1'b0;
          if (!rx_active) begin
            r_state  <= S_DONE;
            pkt_done <= 1'b1;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/usb_rx_pkt.md
USB_RX_PKT -- requirements
Module: usb_rx_pkt

Interface
REQ-001 Parameter MAX_BYTES, default 64, maximum payload bytes per data packet, CRC bytes excluded.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset, sampled on clk rising edge.
REQ-004 rx_active  input  1  high for the full duration of a received packet.
REQ-005 rx_valid  input  1  rx_data carries a byte this cycle; counted only while rx_active=1.
REQ-006 rx_data  input  8  received byte, LSB first on the wire.
REQ-007 rx_error  input  1  line or bit-stuff error from the receive PHY.
REQ-008 pid  output  4  PID nibble of the current or last packet.
REQ-009 is_data  output  1  pid is DATA0 (4'h3), DATA1 (4'hB), DATA2 (4'h7) or MDATA (4'hF).
REQ-010 data_out  output  8  forwarded payload byte.
REQ-011 data_valid  output  1  one-cycle strobe qualifying data_out.
REQ-012 pkt_done  output  1  one-cycle pulse marking end of packet.
REQ-013 crc_ok  output  1  CRC16 check passed; valid with pkt_done and held afterwards.
REQ-014 pkt_err  output  1  packet error; valid with pkt_done and held afterwards.
REQ-015 byte_cnt  output  7  payload bytes forwarded, CRC bytes excluded.

Function
REQ-016 FSM states SHALL be IDLE, PID, DATA, HSK, ERR and DONE.
REQ-017 IDLE->PID when rx_active=1, clearing crc_ok, pkt_err, byte_cnt and the CRC register (16'hFFFF).
REQ-018 In PID, the first valid byte SHALL load pid=rx_data[3:0].
- PID check fails (rx_data[7:4] != ~rx_data[3:0]) -> ERR.
- Data PID -> DATA.
- Any other PID -> HSK.
REQ-019 DATA SHALL pass bytes through a 2-byte delay line.
- On each valid byte beyond the second, the oldest held byte is forwarded: data_out set, data_valid=1 next cycle, byte_cnt+1, CRC updated.
- The two final bytes are never forwarded.
REQ-020 CRC SHALL be USB CRC16: reflected polynomial 16'hA001, init 16'hFFFF, LSB-first, over forwarded bytes only.
REQ-021 On rx_active falling in DATA, crc_ok=1 iff {second held byte, first held byte} == ~crc_reg.
REQ-022 rx_active falling in DATA with fewer than 2 payload-stage bytes -> pkt_err=1, crc_ok=0.
REQ-023 A byte arriving when byte_cnt=MAX_BYTES and 2 bytes are held -> ERR (overflow).
REQ-024 rx_error=1 in PID, DATA or HSK -> ERR the next cycle.
REQ-025 Any valid byte received in HSK -> ERR.
REQ-026 In ERR:
- pkt_err=1 and crc_ok=0.
- No further data_valid.
- Remain in ERR until rx_active=0, then -> DONE.
REQ-027 rx_active=0 in PID, DATA or HSK -> DONE.
REQ-028 DONE SHALL assert pkt_done for exactly one cycle, then -> IDLE.
- pid, is_data, crc_ok, pkt_err and byte_cnt hold until the next IDLE->PID transition.
REQ-029 HSK completion with no byte received SHALL give crc_ok=0 and pkt_err=0.
REQ-030 rx_valid while rx_active=0 SHALL be ignored.
REQ-031 rx_valid and rx_active falling in the same cycle: the byte is not accepted.
REQ-032 data_valid latency SHALL be 1 cycle after acceptance of the byte two positions later.

Reset
REQ-033 On reset=0 at a clk edge:
- FSM -> IDLE.
- pid=0, is_data=0, data_out=0, data_valid=0, pkt_done=0, crc_ok=0, pkt_err=0, byte_cnt=0.
- Delay line and CRC register cleared.
REQ-034 Reset deasserted while rx_active=1 SHALL ignore that packet.
- No pkt_done is produced for it.
- The block re-arms only after rx_active has been seen at 0.

Verification
REQ-035 Bytes C3,00,00 with rx_active -> pid=3, is_data=1, byte_cnt=0, crc_ok=1, pkt_err=0, single pkt_done, no data_valid.
REQ-036 Bytes C3,AA,55,01,02 with CRC bytes corrupted -> data_valid strobes with AA then 55 then 01 then 02 withheld per REQ-019, byte_cnt per forwarded count, crc_ok=0.
REQ-037 Byte D2 (ACK) only -> pid=2, is_data=0, pkt_err=0, crc_ok=0; bytes D2,00 -> pkt_err=1.
REQ-038 Byte C4 (bad check nibble) -> pkt_err=1; rx_error pulse mid-DATA -> data_valid stops, pkt_err=1 at pkt_done.
REQ-039 C3 followed by MAX_BYTES+3 bytes -> overflow, byte_cnt=64, pkt_err=1, one pkt_done after rx_active falls.
REQ-040 reset=0 asserted mid-DATA -> all outputs 0 next cycle, no pkt_done for that packet; next packet decoded normally.
